// File: rtl/mult_share_arb_pkg.sv
// Shared types and widths for the shared-multiplier arbiter and its 4x4 core.
package mult_share_arb_pkg;
  localparam int OP_W     = 4;
  localparam int PROD_W   = 8;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
  } op_t;

  typedef struct packed {
    logic [PROD_W-1:0]   o;
    logic [ID_MAX_W-1:0] id;
  } rsp_t;
endpackage

// File: rtl/mult_share_arb_core.sv
// Purely combinational unsigned 4x4 multiplier shared by all requesters.
module mult_share_arb_core
  import mult_share_arb_pkg::*;
(
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  output logic [PROD_W-1:0] o
);
  assign o = PROD_W'(x) * PROD_W'(y);
endmodule

// File: rtl/mult_share_arb_rr_pick.sv
// Round-robin picker: first set bit of valid at or after ptr, wrapping modulo N.
module mult_share_arb_rr_pick #(
  parameter int N   = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            any
);
  always_comb begin
    grant = '0;
    any   = |valid;
    // Walk from farthest to nearest so the nearest valid index wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % N]) grant = ID_W'((int'(ptr) + k) % N);
    end
  end
endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one 4x4 multiplier among N_REQ requesters through a
// two-stage pipeline (S1 operand register, S2 result register).
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int CNT_W  = 16,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [OP_W*N_REQ-1:0] req_x,
  input  logic [OP_W*N_REQ-1:0] req_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [PROD_W-1:0]     rsp_o,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; ready never depends on payload, and an offered payload may be
  // held across cycles until its handshake consumes it.

  logic            s1_vld, s2_vld;
  op_t             s1_op;
  logic [ID_W-1:0] s1_id;
  rsp_t            s2;
  logic [ID_W-1:0] ptr, g;
  logic            any, adv1, adv2, accept;
  logic [PROD_W-1:0] core_o;

  assign adv2   = !s2_vld || rsp_ready;
  assign adv1   = !s1_vld || adv2;
  assign accept = !rst && any && adv1;

  mult_share_arb_rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (g),
    .any   (any)
  );

  mult_share_arb_core u_core (
    .x (s1_op.x),
    .y (s1_op.y),
    .o (core_o)
  );

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
      s2_vld   <= 1'b0;
      s2       <= '0;
      ptr      <= '0;
      ops_done <= '0;
    end else begin
      if (adv2) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2.o  <= core_o;
          s2.id <= ID_MAX_W'(s1_id);
        end
      end
      if (adv1) begin
        s1_vld <= accept;
        if (accept) begin
          s1_op.x <= req_x[OP_W*g +: OP_W];
          s1_op.y <= req_y[OP_W*g +: OP_W];
          s1_id   <= g;
          ptr     <= (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
        end
      end
      if (rsp_valid && rsp_ready && ops_done != '1) ops_done <= ops_done + 1'b1;
    end
  end

  assign rsp_valid = s2_vld;
  assign rsp_o     = s2.o;
  assign rsp_id    = ID_W'(s2.id);
  assign busy      = s1_vld || s2_vld;
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with an expected-response queue and monitor.
module tb_mult_share_arb;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [4*N-1:0] req_x = '0;
  logic [4*N-1:0] req_y = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [7:0]    rsp_o;
  logic [1:0]    rsp_id;
  logic          busy;
  logic [15:0]   ops_done;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  bit  rand_en = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_o;
  logic [1:0] prev_id;

  mult_share_arb #(.N_REQ(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_o(rsp_o), .rsp_id(rsp_id), .busy(busy), .ops_done(ops_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete();
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: offer one operand until accepted, pushing the expected response
  task automatic send(input int id, input logic [3:0] x, input logic [3:0] y,
                      input logic [7:0] exp_o);
    int  n = 0;
    bit  done = 1'b0;
    logic [1:0] id2;
    id2 = 2'(id);
    req_valid[id] = 1'b1;
    req_x[4*id +: 4] = x;
    req_y[4*id +: 4] = y;
    while (!done) begin
      #1;
      if (req_ready[id]) begin
        exp_q.push_back({id2, exp_o});
        done = 1'b1;
      end
      @(negedge clk);
      n++;
      if (!done && n > 300) begin
        chk("send_timeout", 32'(n), 32'd0);
        done = 1'b1;
      end
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // random consumer backpressure
  always @(negedge clk) if (rand_en) rsp_ready = ($urandom_range(0, 1) == 1);

  // monitor / scoreboard
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_o", 32'(rsp_o), 32'(prev_o));
        chk("stall_id", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {22'd0, rsp_id, rsp_o}, 32'h3ff);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e[9:8]));
          chk("rsp_o", 32'(rsp_o), 32'(e[7:0]));
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_o     = rsp_o;
      prev_id    = rsp_id;
    end
  end

  initial begin
    int accepts;
    // reset and idle
    req_valid = 4'b1111;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_o", 32'(rsp_o), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_ops_done", 32'(ops_done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // single op: 13*11 from requester 2
    rsp_ready = 1'b1;
    send(2, 4'd13, 4'd11, 8'd143);
    #1;
    chk("lat_s1_only", 32'(rsp_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_o", 32'(rsp_o), 32'd143);
    chk("single_id", 32'(rsp_id), 32'd2);
    @(negedge clk);
    #1;
    chk("single_ops_done", 32'(ops_done), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);
    @(negedge clk);

    // round-robin wrap from a fresh pointer
    do_reset(2);
    rsp_ready = 1'b1;
    req_x = {4'd4, 4'd3, 4'd2, 4'd1};
    req_y = {4'd15, 4'd15, 4'd15, 4'd15};
    exp_q.push_back({2'd0, 8'd15});
    exp_q.push_back({2'd1, 8'd30});
    exp_q.push_back({2'd2, 8'd45});
    exp_q.push_back({2'd3, 8'd60});
    exp_q.push_back({2'd0, 8'd15});
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    chk("rr_stream_valid", 32'(rsp_valid), 32'd1);
    chk("rr_stream_id", 32'(rsp_id), 32'd3);
    wait_drain(20);
    chk("rr_ops_done", 32'(ops_done), 32'd5);

    // backpressure from requester 1
    do_reset(2);
    rsp_ready = 1'b0;
    send(1, 4'd15, 4'd15, 8'd225);
    send(1, 4'd0, 4'd9, 8'd0);
    req_valid[1] = 1'b1;
    req_x[7:4] = 4'd8;
    req_y[7:4] = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_o", 32'(rsp_o), 32'd225);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    send(1, 4'd8, 4'd2, 8'd16);
    wait_drain(20);
    chk("bp_ops_done", 32'(ops_done), 32'd3);

    // mid-operation reset with both stages full; ptr left at 3 beforehand
    rsp_ready = 1'b0;
    send(2, 4'd3, 4'd3, 8'd9);
    send(2, 4'd4, 4'd4, 8'd16);
    #1;
    chk("mid_busy_full", 32'(busy), 32'd1);
    do_reset(1);
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ops_done", 32'(ops_done), 32'd0);
    req_x[7:4] = 4'd5;
    req_y[7:4] = 4'd5;
    req_valid = 4'b1010;
    #1;
    chk("mid_ptr_restart", 32'(req_ready), 32'b0010);
    exp_q.push_back({2'd1, 8'd25});
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_drain(20);

    // exhaustive operand pairs, rotating requesters, random consumer
    rand_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      logic [3:0] ex, ey;
      ex = 4'(k >> 4);
      ey = 4'(k);
      send(k % 4, ex, ey, 8'(ex) * 8'(ey));
    end
    wait_drain(400);
    rand_en = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;

    // counter saturation
    do_reset(2);
    req_x[3:0] = 4'd1;
    req_y[3:0] = 4'd1;
    req_valid[0] = 1'b1;
    accepts = 0;
    for (int c = 0; c < 70000 && accepts < 65540; c++) begin
      #1;
      if (req_ready[0]) begin
        exp_q.push_back({2'd0, 8'd1});
        accepts++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("sat_accepts", 32'(accepts), 32'd65540);
    wait_drain(20);
    #1;
    chk("sat_ops_done", 32'(ops_done), 32'hffff);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one 4x4 combinational multiplier core (ports x, y, o; 8-bit product) among N_REQ requesters.
- Each requester has a valid/ready operand handshake. The block arbitrates round-robin and registers operands into the core.
- The product is returned through a single valid/ready response channel tagged with the requester index.
- The block sits between client datapaths and the multiplier; it is the only instance that drives the core.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, $clog2(N_REQ), width of requester tag (derived, not overridden)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester operand valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_x  in  4*N_REQ  operand x, requester i at bits [4i+3:4i]
req_y  in  4*N_REQ  operand y, same packing
rsp_valid  out  1  product valid
rsp_ready  in  1  consumer accepts product
rsp_o  out  8  product x*y, unsigned
rsp_id  out  ID_W  index of the requester that issued the product
busy  out  1  high when either pipeline stage holds data
ops_done  out  CNT_W  count of completed responses, saturating

Behaviour:
- Interface: one clock clk; rst is synchronous and active-high. All state updates occur on the rising clk edge.
- Reset: s1_vld=0, s2_vld=0, ptr=0, ops_done=0. All outputs low/zero: rsp_valid=0, rsp_o=0, rsp_id=0, busy=0, req_ready=0.
- An rst asserted mid-operation drops all in-flight operations without producing responses.
- Pipeline:
  - S1 is the operand register: s1_vld, s1_x, s1_y, s1_id. It drives core x/y.
  - S2 is the result register: s2_vld, s2_o, s2_id. It captures core o and drives the rsp_* outputs.
- Advance rules:
  - adv2 = !s2_vld | rsp_ready
  - adv1 = !s1_vld | adv2
- Transfers:
  - S1->S2 transfer occurs when s1_vld & adv2.
  - S2 empties when rsp_valid & rsp_ready and no S1 data moves in.
- Arbitration, combinational on req_valid and ptr:
  - Search order is ptr, ptr+1, ..., wrapping modulo N_REQ. The first valid requester g is selected.
  - req_ready[g] = adv1 & any(req_valid). All other req_ready bits are 0.
- Accept: on req_valid[g] & req_ready[g], S1 loads {req_x[g], req_y[g], g} and ptr <= (g+1) mod N_REQ, so the pointer wraps from N_REQ-1 to 0.
  - ptr is unchanged when there is no accept.
- Latency: an operand accepted at edge T appears on rsp_* after edge T+1 (2 edges) if there is no backpressure.
- Throughput: 1 operation per cycle while rsp_ready=1.
- Stall: with rsp_ready=0 and both stages full, all req_ready=0. rsp_o and rsp_id hold stable while rsp_valid=1 until accepted.
- req_ready does not depend on req_x/req_y. A requester may hold req_valid across cycles; only a handshake consumes its operands.
- Simultaneous S2 drain and S1->S2 transfer in the same cycle: S2 reloads and rsp_valid stays 1.
- ops_done increments on each rsp_valid & rsp_ready and saturates at all-ones.
- busy = s1_vld | s2_vld.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0; no requester waits more than N_REQ-1 accepts.

Decomposition:
- Shared package holds:
  - localparams OP_W=4 and PROD_W=8
  - typedef op_t {x[OP_W], y[OP_W]}
  - typedef rsp_t {o[PROD_W], id}
- Natural sub-module: rr_pick. It takes req_valid and ptr and produces the grant index g plus an any flag, and is reusable by other shared-resource arbiters.
- The multiplier core is instantiated unchanged inside mult_share_arb.

Test Plan:
- Reset and idle:
  - Stimulus: rst held 2 cycles with req_valid=1111, then released, then all req_valid low.
  - Required: all outputs 0 during reset; rsp_valid=0 and busy=0 while idle.
- Single op:
  - Stimulus: requester 2 issues x=13, y=11 with rsp_ready=1.
  - Required: after 2 edges rsp_valid=1, rsp_o=143, rsp_id=2, ops_done=1.
- Round-robin wrap:
  - Stimulus: all 4 requesters valid, x=i+1, y=15, rsp_ready=1.
  - Required: rsp_id sequence 0,1,2,3,0; products 15,30,45,60 (then 15 again); one response per cycle.
- Backpressure:
  - Stimulus: rsp_ready=0 while streaming 3 ops from requester 1 (x=15,y=15; x=0,y=9; x=8,y=2).
  - Required: the first 2 are accepted, then req_ready=0 and rsp_o holds 225.
  - Then release rsp_ready: responses 225, 0, 16 arrive in order with no loss or duplication.
- Mid-operation reset:
  - Stimulus: rst asserted for 1 cycle while both stages are full.
  - Required: next cycle rsp_valid=0, busy=0, ptr restarts at 0 (the next grant goes to the lowest valid requester).
- Exhaustive and saturation:
  - Exhaustive: all 256 x,y pairs from rotating requesters checked against x*y with random rsp_ready.
  - Saturation: force 65536+ responses and check ops_done sticks at 65535.
